// File: rtl/clk_stop_ctrl.sv
// Clock-stop sequencer: oscillator stabilisation, STOP entry/abort, joypad wake.
// Optional macro CLK_STOP_WAKE_SYNC_EN adds a two-flop WAKE synchroniser.
module clk_stop_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STAB_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       STOP_REQ,
    input  logic       MCYCLE_END,
    input  logic       WAKE,
    output logic       OSC_ENA,
    output logic       CLK_ENA,
    output logic       OSC_STABLE,
    output logic       STOPPED,
    output logic       STOP_ABORT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ST_POR     = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2,
        ST_WAKEUP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAB_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stop_req_q;
    logic             pend_q;
    logic             wake_use;
    logic             stop_rise;

`ifdef CLK_STOP_WAKE_SYNC_EN
    logic wake_s1_q;
    logic wake_s2_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wake_s1_q <= 1'b0;
            wake_s2_q <= 1'b0;
        end else begin
            wake_s1_q <= WAKE;
            wake_s2_q <= wake_s1_q;
        end
    end

    assign wake_use = wake_s2_q;
`else
    assign wake_use = WAKE;
`endif

    assign stop_rise = STOP_REQ & ~stop_req_q;

    // Outputs decode the state held before each edge, so they trail state_q by one CLK.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_POR;
            cnt_q      <= '0;
            stop_req_q <= 1'b0;
            pend_q     <= 1'b0;
            OSC_ENA    <= 1'b1;
            CLK_ENA    <= 1'b0;
            OSC_STABLE <= 1'b0;
            STOPPED    <= 1'b0;
            STOP_ABORT <= 1'b0;
            STATE      <= 2'd0;
        end else begin
            stop_req_q <= STOP_REQ;
            STOP_ABORT <= 1'b0;
            OSC_ENA    <= (state_q != ST_STOPPED);
            CLK_ENA    <= (state_q == ST_RUN);
            OSC_STABLE <= (state_q == ST_RUN);
            STOPPED    <= (state_q == ST_STOPPED) || (state_q == ST_WAKEUP);
            STATE      <= state_q;

            case (state_q)
                ST_POR, ST_WAKEUP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if ((pend_q || stop_rise) && MCYCLE_END) begin
                        pend_q <= 1'b0;
                        if (wake_use) begin
                            STOP_ABORT <= 1'b1;
                        end else begin
                            state_q <= ST_STOPPED;
                        end
                    end else if (stop_rise) begin
                        pend_q <= 1'b1;
                    end
                end
                ST_STOPPED: begin
                    if (wake_use) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAKEUP;
                    end
                end
                default: begin
                    state_q <= ST_POR;
                end
            endcase
        end
    end

endmodule

// File: doc/clk_stop_ctrl.md
Name: clk_stop_ctrl

Overview:
- Sequencer for the external clock/reset generator: drives its OSC_ENA and CLK_ENA inputs and replaces the tied-high 16 Hz oscillator-stable qualifier.
- Handles power-on oscillator stabilisation, SM83 STOP entry at an M-cycle boundary, wake on joypad, and re-stabilisation before CPU clocks resume.
- Sits between the CPU core / joypad block and the clock generator.

Parameters:
- CNT_W, 16, width of the stabilisation counter.
- STAB_CYCLES, 1024, CLK cycles the oscillator is held enabled before CLK_ENA is raised. Legal range is 1 to 2^CNT_W-1.

Ports:
- CLK  input  1  free-running 4 MHz oscillator clock; all state changes on the rising edge.
- nRESET  input  1  asynchronous, active-low reset.
- STOP_REQ  input  1  CPU executing STOP; level, acted on at its rising edge only.
- MCYCLE_END  input  1  one-CLK strobe marking the last CLK of an M-cycle (BOGA boundary).
- WAKE  input  1  joypad any-key-pressed, level.
- OSC_ENA  output  1  to clock generator OSC_ENA.
- CLK_ENA  output  1  to clock generator CLK_ENA.
- OSC_STABLE  output  1  replaces the SixteenHz qualifier.
- STOPPED  output  1  high in STOPPED and WAKEUP.
- STOP_ABORT  output  1  one-CLK pulse when STOP is refused.
- STATE  output  2  debug: 0=POR, 1=RUN, 2=STOPPED, 3=WAKEUP.

Behaviour:
- All outputs are registered.
- nRESET low forces asynchronously: state=POR, cnt=0, stop_req_d=0, OSC_ENA=1, CLK_ENA=0, OSC_STABLE=0, STOPPED=0, STOP_ABORT=0, STATE=0.
- stop_rise = STOP_REQ & ~stop_req_d, where stop_req_d is STOP_REQ delayed one CLK.
- POR:
  - cnt increments each CLK.
  - When cnt==STAB_CYCLES-1: cnt<=0, go to RUN.
  - CLK_ENA and OSC_STABLE therefore rise exactly STAB_CYCLES+1 rising edges after nRESET deassertion (counter edges plus the output register).
- RUN (OSC_ENA=1, CLK_ENA=1, OSC_STABLE=1, STOPPED=0):
  - stop_rise sets a pending flag.
  - With the flag (or stop_rise) active and MCYCLE_END=1:
    - WAKE=0: go to STOPPED, clear the flag.
    - WAKE=1: stay in RUN, pulse STOP_ABORT, clear the flag.
  - If stop_rise and MCYCLE_END occur in the same cycle, act immediately.
- STOPPED (OSC_ENA=0, CLK_ENA=0, OSC_STABLE=0, STOPPED=1):
  - CLK_ENA and OSC_ENA fall in the same cycle, one edge after entry.
  - WAKE=1: cnt<=0, go to WAKEUP.
- WAKEUP (OSC_ENA=1, CLK_ENA=0, OSC_STABLE=0, STOPPED=1):
  - cnt increments each CLK; at STAB_CYCLES-1 go to RUN.
  - WAKE falling during WAKEUP is ignored; the count always completes.
- STOP_REQ in POR, STOPPED or WAKEUP is ignored, and no pending flag is set.
- A STOP_REQ level still held high after returning to RUN does not re-enter STOP; a new rising edge is required.
- MCYCLE_END outside RUN is ignored.
- Asserting nRESET in any state, mid-count included, returns to POR and restarts the full count.
- cnt never wraps: it is cleared on every state exit.
- STAB_CYCLES=1 gives a one-cycle POR and WAKEUP.

Optional Feature:
- Macro CLK_STOP_WAKE_SYNC_EN.
- Defined:
  - WAKE passes through a two-flop synchroniser (reset 0) before all use.
  - STOPPED->WAKEUP occurs 2 CLK later than without the macro.
  - The RUN abort check uses the synchronised value.
- Undefined: WAKE is used directly; it is assumed synchronous to CLK.

Test Plan:
1. STAB_CYCLES=8; release nRESET, WAKE=0, STOP_REQ=0 -> OSC_ENA=1 throughout; CLK_ENA and OSC_STABLE rise on the 9th rising edge after release; STATE 0->1.
2. In RUN, pulse STOP_REQ 3 CLK before MCYCLE_END -> STATE=2 one edge after MCYCLE_END; OSC_ENA=CLK_ENA=OSC_STABLE=0; STOPPED=1.
3. From STOPPED, assert WAKE for 1 CLK -> STATE=3, OSC_ENA=1, CLK_ENA stays 0 for 8 CLK, then STATE=1 and CLK_ENA=1. With CLK_STOP_WAKE_SYNC_EN defined, the same sequence runs 2 CLK later.
4. In RUN, WAKE=1, STOP_REQ rising with MCYCLE_END in the same cycle -> STATE stays 1; STOP_ABORT high for exactly 1 CLK; CLK_ENA never drops.
5. Hold STOP_REQ high through a full stop/wake cycle -> after returning to RUN, no second STOP despite MCYCLE_END strobes; toggling STOP_REQ low then high re-enters STOPPED.
6. Assert nRESET at cnt=4 of WAKEUP -> immediately STATE=0, OSC_ENA=1, CLK_ENA=0, STOPPED=0; full 8-cycle POR count before RUN.
